// File: rtl/note_pkg.sv
// Shared types for the note peak tracker: FSM states, magnitude width, and the peak entry record.
package note_pkg;
    localparam int PKG_BIT_WIDTH = 16;
    localparam int BIN_W         = 9;
    localparam int MAG_W         = PKG_BIT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic [MAG_W-1:0] mag;
        logic             valid;
    } peak_t;
endpackage

// File: rtl/note_peak_tracker_peak_insert.sv
// Combinational sorted insert: K entries, descending by magnitude, plus one candidate in; K entries out.
module peak_insert
    import note_pkg::*;
#(
    parameter int K = 3
) (
    input  peak_t [K-1:0] list_in,
    input  peak_t         cand,
    output peak_t [K-1:0] list_out
);

    logic [K-1:0] beats;

    // Candidates arrive in ascending bin order, so an equal magnitude never displaces an entry.
    always_comb begin
        beats = '0;
        for (int i = 0; i < K; i++) begin
            beats[i] = cand.valid && (!list_in[i].valid || (cand.mag > list_in[i].mag));
        end
        list_out[0] = beats[0] ? cand : list_in[0];
        for (int i = 1; i < K; i++) begin
            if (!beats[i]) begin
                list_out[i] = list_in[i];
            end else if (!beats[i-1]) begin
                list_out[i] = cand;
            end else begin
                list_out[i] = list_in[i-1];
            end
        end
    end

endmodule

// File: rtl/note_peak_tracker.sv
// Scans one half-spectrum per FFT frame, keeps the strongest local maxima,
// and commits them once the bin set has held for STABLE_FRAMES frames.
//
// state  | meaning
// IDLE   | waiting for fft_done
// SCAN   | driving read addresses MIN_BIN-1 .. FFT_SIZE/2
// DRAIN  | two cycles for the last read and last insert to land
// COMMIT | compare with previous frame, update stability, maybe load outputs
module note_peak_tracker
    import note_pkg::*;
#(
    parameter int BIT_WIDTH     = 16,
    parameter int N             = 9,
    parameter int FFT_SIZE      = 512,
    parameter int NUM_PEAKS     = 3,
    parameter int MIN_BIN       = 1,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fft_done,
    output logic [N-1:0]                         add_rd,
    input  logic [2*BIT_WIDTH-1:0]               fft_result,
    input  logic [BIT_WIDTH:0]                   thresh,
    output logic [NUM_PEAKS*N-1:0]               peak_bin,
    output logic [NUM_PEAKS*(BIT_WIDTH+1)-1:0]   peak_mag,
    output logic [NUM_PEAKS-1:0]                 peak_valid,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 overrun
);

    localparam int MW = BIT_WIDTH + 1;
    localparam int CW = $clog2(STABLE_FRAMES + 1);
    localparam logic [N-1:0] FIRST_ADDR = N'(MIN_BIN - 1);
    localparam logic [N-1:0] LAST_ADDR  = N'(FFT_SIZE / 2);

    state_t state, state_nxt;
    logic                     drain_cnt;
    logic                     rd_vld;
    logic [N-1:0]             rd_bin;
    logic [MW-1:0]            mag_cur, mag_q0, mag_q1, thr_q;
    logic [CW-1:0]            stable_cnt, stable_nxt;
    logic                     match;
    peak_t [NUM_PEAKS-1:0]    work, work_ins, prev;
    peak_t                    cand;
    logic                     start;

    function automatic logic [BIT_WIDTH-1:0] abs_val(input logic [BIT_WIDTH-1:0] v);
        return v[BIT_WIDTH-1] ? (~v + BIT_WIDTH'(1)) : v;
    endfunction

    // Exact: the most negative input maps to 2^(BIT_WIDTH-1), so the sum needs one extra bit.
    assign mag_cur = MW'(abs_val(fft_result[2*BIT_WIDTH-1:BIT_WIDTH]))
                   + MW'(abs_val(fft_result[BIT_WIDTH-1:0]));

    assign start      = (state == IDLE) && fft_done;
    assign busy       = (state != IDLE);
    assign frame_done = (state == COMMIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fft_done) state_nxt = SCAN;
            SCAN:    if (add_rd == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 1'b0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mag_q0 holds bin rd_bin-1 and mag_q1 bin rd_bin-2 while the current read is bin rd_bin.
    always_comb begin
        cand       = '0;
        cand.bin   = rd_bin - N'(1);
        cand.mag   = mag_q0;
        cand.valid = rd_vld && (rd_bin >= N'(MIN_BIN + 1)) && (mag_q0 >= thr_q)
                     && (mag_q0 > mag_q1) && (mag_q0 >= mag_cur);
    end

    peak_insert #(.K(NUM_PEAKS)) u_insert (
        .list_in  (work),
        .cand     (cand),
        .list_out (work_ins)
    );

    always_comb begin
        match = 1'b1;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            if ((work[i].bin != prev[i].bin) || (work[i].valid != prev[i].valid)) match = 1'b0;
        end
        stable_nxt = CW'(1);
        if (match) begin
            stable_nxt = (stable_cnt == CW'(STABLE_FRAMES)) ? stable_cnt : stable_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            drain_cnt  <= 1'b0;
            add_rd     <= '0;
            rd_vld     <= 1'b0;
            rd_bin     <= '0;
            mag_q0     <= '0;
            mag_q1     <= '0;
            thr_q      <= '0;
            work       <= '0;
            prev       <= '0;
            stable_cnt <= '0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_valid <= '0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= fft_done && busy;
            rd_vld  <= (state == SCAN);
            rd_bin  <= add_rd;

            if (state == SCAN)       drain_cnt <= 1'b1;
            else if (state == DRAIN) drain_cnt <= drain_cnt - 1'b1;

            if (start) begin
                add_rd <= FIRST_ADDR;
                thr_q  <= thresh;
            end else if ((state == SCAN) && (state_nxt == SCAN)) begin
                add_rd <= add_rd + N'(1);
            end

            if (rd_vld) begin
                mag_q0 <= mag_cur;
                mag_q1 <= mag_q0;
            end

            if (start)           work <= '0;
            else if (cand.valid) work <= work_ins;

            if (state == COMMIT) begin
                prev       <= work;
                stable_cnt <= stable_nxt;
                if (stable_nxt == CW'(STABLE_FRAMES)) begin
                    for (int i = 0; i < NUM_PEAKS; i++) begin
                        peak_bin[i*N +: N]   <= work[i].bin;
                        peak_mag[i*MW +: MW] <= work[i].mag;
                        peak_valid[i]        <= work[i].valid;
                    end
                end
            end
        end
    end

endmodule

// File: doc/note_peak_tracker.md
NOTE_PEAK_TRACKER -- requirements
Module: note_peak_tracker

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BIT_WIDTH, 16: width of each signed FFT real/imag component.
- N, 9: FFT address width.
- FFT_SIZE, 512: FFT points.
- NUM_PEAKS, 3: number of tracked peaks, K ≥ 1.
- MIN_BIN, 1: lowest scanned bin, 1 ≤ MIN_BIN < FFT_SIZE/2−1.
- STABLE_FRAMES, 3: consecutive identical frames required before commit, ≥ 1.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; all state is on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- fft_done, in, 1: one-cycle pulse; FFT result RAM holds a valid frame.
- add_rd, out, N: FFT result RAM read address.
- fft_result, in, 2*BIT_WIDTH: {re, im}, both signed, valid exactly 1 cycle after add_rd.
- thresh, in, BIT_WIDTH+1: unsigned minimum peak magnitude, sampled at frame start.
- peak_bin, out, NUM_PEAKS*N: committed peak bins; slot 0 in the LSBs and the strongest.
- peak_mag, out, NUM_PEAKS*(BIT_WIDTH+1): committed magnitudes, same slot order.
- peak_valid, out, NUM_PEAKS: per-slot valid for the committed set.
- busy, out, 1: high in any state other than IDLE.
- frame_done, out, 1: one-cycle pulse at the end of every frame.
- overrun, out, 1: one-cycle pulse when fft_done arrives while busy.

Function
REQ-003 Magnitude is computed as mag = |re| + |im|, unsigned BIT_WIDTH+1 bits, exact with no saturation (−32768 maps to 32768).
REQ-004 FSM states are IDLE, SCAN, DRAIN, COMMIT. IDLE goes to SCAN on fft_done. SCAN goes to DRAIN after the last address. DRAIN lasts 2 cycles, then goes to COMMIT. COMMIT lasts 1 cycle, then returns to IDLE.
REQ-005 SCAN drives add_rd over MIN_BIN−1 .. FFT_SIZE/2 ascending, one address per cycle. The first address is driven in the cycle after fft_done is sampled.
REQ-006 Bin k (MIN_BIN ≤ k ≤ FFT_SIZE/2−1) is a candidate only if all of the following hold:
- mag(k) ≥ thresh
- mag(k) > mag(k−1)
- mag(k) ≥ mag(k+1)
REQ-007 The candidate check uses a 3-deep magnitude pipeline. The decision for bin k is made in the cycle mag(k+1) arrives.
REQ-008 Candidates enter a sorted working list of NUM_PEAKS entries, descending by magnitude.
- On equal magnitude, the earlier (lower) bin ranks higher.
- When the list is full, the weakest entry is discarded.
- The working list is cleared at frame start.
REQ-009 In COMMIT, the working list is compared with the previous frame's list, matching on bins and valid flags, slot by slot.
- On a match, the stable counter increments, saturating at STABLE_FRAMES.
- On a mismatch, the counter resets to 1.
REQ-010 When the stable counter equals STABLE_FRAMES in COMMIT, peak_bin, peak_mag and peak_valid are loaded from the working list. Otherwise the committed outputs hold.
REQ-011 frame_done pulses exactly FFT_SIZE/2 − MIN_BIN + 5 cycles after the cycle in which fft_done is sampled.
REQ-012 fft_done while busy:
- pulses overrun in the following cycle;
- is otherwise ignored;
- the current frame completes unchanged.
REQ-013 fft_done coincident with the COMMIT cycle is treated as overrun. fft_done in the cycle after COMMIT starts a new frame normally.
REQ-014 thresh changes during a frame have no effect until the next frame start.
REQ-015 Unused slots (fewer candidates than NUM_PEAKS) have valid = 0, with bin and magnitude reading 0.

Reset
REQ-016 On reset low, asynchronously and regardless of state:
- the FSM enters IDLE;
- add_rd, peak_bin, peak_mag, peak_valid, frame_done, overrun, busy, the stable counter and both lists go to 0.
REQ-017 Reset asserted mid-SCAN abandons the frame. No frame_done is produced and committed outputs read 0 after release.
REQ-018 The first fft_done after reset release is accepted normally.

Structure
REQ-019 A shared package note_pkg holds:
- the FSM state enum;
- the magnitude width constant (BIT_WIDTH+1);
- the peak entry struct {bin, mag, valid}.
REQ-020 The sorted-insert logic is one sub-module, peak_insert. It is combinational: K entries plus one candidate in, K entries out.

Verification
Common setup for REQ-021 to REQ-025: FFT_SIZE=512, MIN_BIN=1, K=3, STABLE_FRAMES=3. The bench models a 1-cycle-latency RAM.

REQ-021 Single tone: bin 10 = (1000, 0), all others 0, thresh=100, three frames.
- frame_done comes 260 cycles after each fft_done.
- After frame 3: peak_bin[0]=10, peak_mag[0]=1000, peak_valid=3'b001.
- After frames 1 and 2, peak_valid is still 0.
REQ-022 Four tones: bins 20/40/60/80 with magnitudes 500/900/700/300, held 3 frames.
- Committed order is bins 40, 60, 20, with peak_valid=3'b111.
REQ-023 Boundary rules:
- Plateau: bins 30 and 31 both 400 gives candidate 30 only.
- Tie: bins 50 and 70 both 600 ranks 50 before 70.
- Threshold: bin 90 = 99 with thresh=100 is not reported.
REQ-024 Extreme values: bin 5 = (−32768, −32768) gives peak_mag[0]=65536, with no wrap.
REQ-025 Event timing:
- Overrun: a second fft_done 100 cycles into a scan pulses overrun once, and frame_done still occurs at 260 cycles.
- Stability loss: frames alternate between bin 10 and bin 12; outputs never update and hold their prior committed values.
REQ-026 Reset mid-scan: reset low at cycle 50 of a frame.
- busy=0 and all outputs are 0 immediately.
- No frame_done follows.
- The next fft_done produces a normal frame.
